// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM sample stream to parallel per-channel lanes demultiplexer
//
// Purpose:
//   Collects consecutive samples of a time-division-multiplexed stream into
//   CHANNELS lanes. A sync-qualified sample marks channel 0. Lanes 0..CHANNELS-2
//   are held in a shadow register while the frame is being collected. The
//   published bus is updated atomically, together with a one-cycle y_valid
//   pulse, when the last sample is captured.
//
// Optional feature (macro TDM_DEMUX_PARITY_EN):
//   Adds an even-parity input x_par and a y_par_err pulse output. A frame that
//   contains any accepted sample with bad parity is discarded at completion.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   x_data       incoming sample (WIDTH bits)
//   x_valid      sample present this cycle
//   x_sync       sample is channel 0 of a new frame (only when x_valid=1)
//   x_par        even parity over x_data        (TDM_DEMUX_PARITY_EN only)
//   y_par_err    pulse: frame dropped for parity (TDM_DEMUX_PARITY_EN only)
//   y_bus        published frame, lane k = y_bus[k*WIDTH +: WIDTH]
//   y_valid      pulse: y_bus holds a new complete frame
//   y_busy       frame partially collected
//   y_idx        next channel slot expected (0 when idle)
//   y_frame_err  pulse: sync arrived mid-frame, partial frame discarded

module tdm_demux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          x_data,
  input  logic                      x_valid,
  input  logic                      x_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                      x_par,
  output logic                      y_par_err,
`endif
  output logic [CHANNELS*WIDTH-1:0] y_bus,
  output logic                      y_valid,
  output logic                      y_busy,
  output logic [IDX_W-1:0]          y_idx,
  output logic                      y_frame_err
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          shadow_q [0:CHANNELS-2];
  logic [WIDTH-1:0]          shadow_d [0:CHANNELS-2];
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CHANNELS*WIDTH-1:0] bus_q, bus_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  // Sticky mark: some accepted sample of the current frame had bad parity.
  logic                      bad_q, bad_d;
  logic                      par_bad;
  logic                      last_slot;

`ifdef TDM_DEMUX_PARITY_EN
  logic                      perr_q, perr_d;

  // Even parity: x_par must equal the XOR of all data bits.
  assign par_bad = (x_par != ^x_data);
`else
  assign par_bad = 1'b0;
`endif

  assign last_slot = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bus_d   = bus_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    bad_d   = bad_q;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d  = 1'b0;
`endif
    for (int k = 0; k < CHANNELS - 1; k++) begin
      shadow_d[k] = shadow_q[k];
    end

    case (state_q)
      S_IDLE: begin
        // Non-sync samples in idle are dropped without any report.
        if (x_valid && x_sync) begin
          shadow_d[0] = x_data;
          idx_d       = ONE_IDX;
          bad_d       = par_bad;
          state_d     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (x_valid) begin
          if (x_sync) begin
            // Restart: old partial frame is discarded, bad mark restarts
            // from this sample alone.
            ferr_d      = 1'b1;
            shadow_d[0] = x_data;
            idx_d       = ONE_IDX;
            bad_d       = par_bad;
          end else if (!last_slot) begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
              if (idx_q == IDX_W'(k)) begin
                shadow_d[k] = x_data;
              end
            end
            idx_d = idx_q + ONE_IDX;
            bad_d = bad_q | par_bad;
          end else begin
            // Last sample: publish straight from the shadow plus this sample.
            idx_d   = '0;
            bad_d   = 1'b0;
            state_d = S_IDLE;
            if (bad_q || par_bad) begin
`ifdef TDM_DEMUX_PARITY_EN
              perr_d = 1'b1;
`endif
            end else begin
              for (int k = 0; k < CHANNELS - 1; k++) begin
                bus_d[k*WIDTH +: WIDTH] = shadow_q[k];
              end
              bus_d[(CHANNELS-1)*WIDTH +: WIDTH] = x_data;
              valid_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        bad_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      bad_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      for (int k = 0; k < CHANNELS - 1; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      bad_q   <= bad_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q  <= perr_d;
`endif
      for (int k = 0; k < CHANNELS - 1; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign y_bus       = bus_q;
  assign y_valid     = valid_q;
  assign y_busy      = (state_q == S_COLLECT);
  assign y_idx       = idx_q;
  assign y_frame_err = ferr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign y_par_err   = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux

module tb_tdm_demux;

  logic        clk;
  logic        rst;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_sync;
  logic        x_par;
  logic        y_par_err;
  logic [63:0] y_bus;
  logic        y_valid;
  logic        y_busy;
  logic [3:0]  y_idx;
  logic        y_frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_demux #(.WIDTH(16), .CHANNELS(4), .IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .x_data      (x_data),
    .x_valid     (x_valid),
    .x_sync      (x_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .x_par       (x_par),
    .y_par_err   (y_par_err),
`endif
    .y_bus       (y_bus),
    .y_valid     (y_valid),
    .y_busy      (y_busy),
    .y_idx       (y_idx),
    .y_frame_err (y_frame_err)
  );

`ifndef TDM_DEMUX_PARITY_EN
  assign y_par_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input cycle, then wait until just after the capturing edge.
  task automatic cyc(input logic v, input logic s, input logic [15:0] d,
                     input logic bad_par);
    x_valid = v;
    x_sync  = s;
    x_data  = d;
    x_par   = (^d) ^ bad_par;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (y_bus !== 64'h0 || y_valid !== 1'b0 || y_busy !== 1'b0 ||
        y_idx !== 4'd0 || y_frame_err !== 1'b0 || y_par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: bus=%h valid=%b busy=%b idx=%0d ferr=%b perr=%b, required all 0",
               y_bus, y_valid, y_busy, y_idx, y_frame_err, y_par_err);
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_basic_frame();
    logic [15:0] smp [4];
    logic [3:0]  exp_idx [4];
    logic        exp_busy [4];
    smp      = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    exp_idx  = '{4'd1, 4'd2, 4'd3, 4'd0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), smp[i], 1'b0);
      n_checks++;
      if (y_idx !== exp_idx[i] || y_busy !== exp_busy[i] || y_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_step%0d: idx=%0d busy=%b valid=%b, required idx=%0d busy=%b valid=%b",
                 i, y_idx, y_busy, y_valid, exp_idx[i], exp_busy[i], (i == 3));
      end
    end
    n_checks++;
    if (y_bus !== 64'h0004_0003_0002_0001) begin
      n_fail++;
      $display("FAIL basic_bus: got %h required %h", y_bus, 64'h0004_0003_0002_0001);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_single: valid=%b required 0", y_valid);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] smp [4];
    int vcount;
    int vlast;
    smp    = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    vcount = 0;
    vlast  = -1;
    // Clear the published bus first so a stale bus cannot satisfy the check.
    rst = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), smp[i], 1'b0);
      if (y_valid) begin vcount++; vlast = i; end
      for (int g = 0; g < 2; g++) begin
        cyc(1'b0, 1'b0, 16'hDEAD, 1'b0);
        if (y_valid) begin vcount++; vlast = 100 + i; end
      end
    end
    n_checks++;
    if (vcount !== 1 || vlast !== 3) begin
      n_fail++;
      $display("FAIL gaps_valid: pulses=%0d at=%0d, required 1 at 3", vcount, vlast);
    end
    n_checks++;
    if (y_bus !== 64'h0004_0003_0002_0001) begin
      n_fail++;
      $display("FAIL gaps_bus: got %h required %h", y_bus, 64'h0004_0003_0002_0001);
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] smp [6];
    logic        syn [6];
    int ferr_count;
    int vcount;
    smp = '{16'hAAAA, 16'hBBBB, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    syn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ferr_count = 0;
    vcount     = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, syn[i], smp[i], 1'b0);
      if (y_frame_err) ferr_count++;
      if (y_valid) vcount++;
      if (i == 2) begin
        n_checks++;
        if (y_frame_err !== 1'b1 || y_idx !== 4'd1 || y_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ferr_restart: ferr=%b idx=%0d busy=%b, required 1 1 1",
                   y_frame_err, y_idx, y_busy);
        end
      end
    end
    n_checks++;
    if (ferr_count !== 1 || vcount !== 1 || y_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_counts: ferr_pulses=%0d valid_pulses=%0d last_valid=%b, required 1 1 1",
               ferr_count, vcount, y_valid);
    end
    n_checks++;
    if (y_bus !== 64'h4444_3333_2222_1111) begin
      n_fail++;
      $display("FAIL ferr_bus: got %h required %h", y_bus, 64'h4444_3333_2222_1111);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_idle_drop();
    cyc(1'b1, 1'b0, 16'h00FF, 1'b0);
    cyc(1'b1, 1'b0, 16'h00EE, 1'b0);
    n_checks++;
    if (y_busy !== 1'b0 || y_idx !== 4'd0 || y_valid !== 1'b0 ||
        y_bus !== 64'h4444_3333_2222_1111) begin
      n_fail++;
      $display("FAIL idle_drop: busy=%b idx=%0d valid=%b bus=%h, required 0 0 0 %h",
               y_busy, y_idx, y_valid, y_bus, 64'h4444_3333_2222_1111);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp [8];
    int vcyc [$];
    smp = '{16'h0010, 16'h0011, 16'h0012, 16'h0013,
            16'h0020, 16'h0021, 16'h0022, 16'h0023};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (i % 4 == 0), smp[i], 1'b0);
      if (y_valid) vcyc.push_back(i);
      if (i == 3) begin
        n_checks++;
        if (y_bus !== 64'h0013_0012_0011_0010) begin
          n_fail++;
          $display("FAIL b2b_bus_a: got %h required %h", y_bus, 64'h0013_0012_0011_0010);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (y_busy !== 1'b1 || y_idx !== 4'd1) begin
          n_fail++;
          $display("FAIL b2b_no_bubble: busy=%b idx=%0d, required 1 1", y_busy, y_idx);
        end
      end
    end
    n_checks++;
    if (vcyc.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d pulses required 2", vcyc.size());
    end else if (vcyc[1] - vcyc[0] !== 4) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles required 4", vcyc[1] - vcyc[0]);
    end
    n_checks++;
    if (y_bus !== 64'h0023_0022_0021_0020) begin
      n_fail++;
      $display("FAIL b2b_bus_b: got %h required %h", y_bus, 64'h0023_0022_0021_0020);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int vcount;
    vcount = 0;
    cyc(1'b1, 1'b1, 16'h0A01, 1'b0);
    cyc(1'b1, 1'b0, 16'h0A02, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 16'h0A03, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (y_bus !== 64'h0 || y_valid !== 1'b0 || y_busy !== 1'b0 ||
        y_idx !== 4'd0 || y_frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: bus=%h valid=%b busy=%b idx=%0d ferr=%b, required all 0",
               y_bus, y_valid, y_busy, y_idx, y_frame_err);
    end
    // Trailing sample of the killed frame must be dropped as idle non-sync.
    cyc(1'b1, 1'b0, 16'h0A04, 1'b0);
    if (y_valid) vcount++;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), 16'h0B00 + 16'(i), 1'b0);
      if (y_valid) vcount++;
    end
    n_checks++;
    if (vcount !== 1 || y_bus !== 64'h0B03_0B02_0B01_0B00) begin
      n_fail++;
      $display("FAIL midrst_next: pulses=%0d bus=%h, required 1 %h",
               vcount, y_bus, 64'h0B03_0B02_0B01_0B00);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    int vcount;
    vcount = 0;
    // Bad parity on a dropped idle sample must not report.
    cyc(1'b1, 1'b0, 16'h0007, 1'b1);
    n_checks++;
    if (y_par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_idle_drop: perr=%b required 0", y_par_err);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), 16'h0C00 + 16'(i), (i == 1));
      if (y_valid) vcount++;
    end
    n_checks++;
    if (y_par_err !== 1'b1 || vcount !== 0 || y_busy !== 1'b0 ||
        y_bus !== 64'h0B03_0B02_0B01_0B00) begin
      n_fail++;
      $display("FAIL par_bad_frame: perr=%b valid_pulses=%0d busy=%b bus=%h, required 1 0 0 %h",
               y_par_err, vcount, y_busy, y_bus, 64'h0B03_0B02_0B01_0B00);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), 16'h0D00 + 16'(i), 1'b0);
      if (y_valid) vcount++;
    end
    n_checks++;
    if (y_par_err !== 1'b0 || vcount !== 1 || y_bus !== 64'h0D03_0D02_0D01_0D00) begin
      n_fail++;
      $display("FAIL par_clean_next: perr=%b valid_pulses=%0d bus=%h, required 0 1 %h",
               y_par_err, vcount, y_bus, 64'h0D03_0D02_0D01_0D00);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask
`endif

  initial begin
    rst     = 1'b1;
    x_data  = '0;
    x_valid = 1'b0;
    x_sync  = 1'b0;
    x_par   = 1'b0;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_frame_err();
    test_idle_drop();
    test_back_to_back();
    test_mid_reset();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
